// File: rtl/msrh_sched_age_picker.sv
// Occupancy and age-ordering controller for one scheduler bank: hands free
// entries to dispatch slots, tracks relative age and picks the oldest ready entry.
module msrh_sched_age_picker #(
    parameter int ENTRY_SIZE = 16,
    parameter int DISP_SIZE  = 2
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [DISP_SIZE-1:0]            i_disp_valid,
    output logic                            o_alloc_ready,
    output logic [DISP_SIZE*ENTRY_SIZE-1:0] o_alloc_oh,
    input  logic [ENTRY_SIZE-1:0]           i_entry_ready,
    input  logic                            i_pick_stall,
    output logic                            o_pick_valid,
    output logic [ENTRY_SIZE-1:0]           o_pick_oh,
    input  logic [ENTRY_SIZE-1:0]           i_entry_finish,
    output logic [$clog2(ENTRY_SIZE+1)-1:0] o_free_count,
    output logic                            o_empty
);

    localparam int CW = $clog2(ENTRY_SIZE + 1);

    logic [ENTRY_SIZE-1:0]                  valid_q, valid_d;
    logic [ENTRY_SIZE-1:0][ENTRY_SIZE-1:0]  age_q, age_d;
    logic [CW-1:0]                          freeCount_q, freeCount_d;

    logic [DISP_SIZE-1:0][ENTRY_SIZE-1:0]   allocOh;
    logic [ENTRY_SIZE-1:0]                  allocAny;
    logic [ENTRY_SIZE-1:0]                  freeMask;
    logic [ENTRY_SIZE-1:0]                  grant;
    logic                                   found;
    logic [ENTRY_SIZE-1:0]                  finishVec;
    logic [ENTRY_SIZE-1:0]                  olderMask;
    logic [ENTRY_SIZE-1:0]                  cand;
    logic [ENTRY_SIZE-1:0]                  blockedVec;
    logic [ENTRY_SIZE-1:0]                  pickRaw;
    int                                     nextCount;

    assign o_alloc_ready = (freeCount_q >= CW'(DISP_SIZE));
    assign o_alloc_oh    = allocOh;
    assign finishVec     = i_entry_finish & valid_q;
    assign o_free_count  = freeCount_q;
    assign o_empty       = ~|valid_q;

    // k-th requesting slot takes the k-th lowest-index free entry
    always_comb begin
        freeMask = ~valid_q;
        allocOh  = '0;
        allocAny = '0;
        grant    = '0;
        found    = 1'b0;
        for (int s = 0; s < DISP_SIZE; s++) begin
            grant = '0;
            found = 1'b0;
            for (int k = 0; k < ENTRY_SIZE; k++) begin
                if (!found && freeMask[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
            if (i_disp_valid[s] && o_alloc_ready) begin
                allocOh[s] = grant;
                freeMask   = freeMask & ~grant;
                allocAny   = allocAny | grant;
            end
        end
    end

    // Surviving entries and earlier slots of this cycle are older than each new entry
    always_comb begin
        age_d = age_q;
        for (int k = 0; k < ENTRY_SIZE; k++) begin
            if (finishVec[k]) begin
                age_d[k] = '0;
                for (int j = 0; j < ENTRY_SIZE; j++) age_d[j][k] = 1'b0;
            end
        end
        olderMask = valid_q & ~finishVec;
        for (int s = 0; s < DISP_SIZE; s++) begin
            for (int k = 0; k < ENTRY_SIZE; k++) begin
                if (allocOh[s][k]) begin
                    age_d[k] = '0;
                    for (int j = 0; j < ENTRY_SIZE; j++) age_d[j][k] = olderMask[j];
                end
            end
            olderMask = olderMask | allocOh[s];
        end
    end

    always_comb begin
        valid_d   = (valid_q & ~finishVec) | allocAny;
        nextCount = int'(freeCount_q);
        for (int s = 0; s < DISP_SIZE; s++) if (|allocOh[s]) nextCount = nextCount - 1;
        for (int k = 0; k < ENTRY_SIZE; k++) if (finishVec[k]) nextCount = nextCount + 1;
        freeCount_d = CW'(nextCount);
    end

    // An entry is picked when no other ready candidate is older than it
    always_comb begin
        cand       = valid_q & i_entry_ready;
        blockedVec = '0;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            for (int j = 0; j < ENTRY_SIZE; j++) begin
                blockedVec[i] = blockedVec[i] | (cand[j] & age_q[j][i]);
            end
        end
        pickRaw      = cand & ~blockedVec;
        o_pick_valid = (|cand) & ~i_pick_stall;
        o_pick_oh    = i_pick_stall ? '0 : pickRaw;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q     <= '0;
            age_q       <= '0;
            freeCount_q <= CW'(ENTRY_SIZE);
        end else begin
            valid_q     <= valid_d;
            age_q       <= age_d;
            freeCount_q <= freeCount_d;
        end
    end

    finishOnValid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (i_entry_finish & ~valid_q) == '0);
    pickOneHot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_pick_oh));
    freeCountBound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        freeCount_q <= CW'(ENTRY_SIZE));

endmodule
